// File: rtl/weight_loader_if.sv
// Weight-loader bus: the framed weight stream in, and the registered RAM write port out.
// The slave modport is the loader's view; master is the host/RAM side.
interface weight_loader_if #(
   parameter int DIN_WIDTH = 16,
   parameter int ADDR_W    = 8
);
   logic [DIN_WIDTH-1:0] din;
   logic                 din_valid;
   logic                 din_last;
   logic                 din_ready;
   logic                 bram_we;
   logic [ADDR_W-1:0]    bram_addr;
   logic [DIN_WIDTH-1:0] bram_din;

   modport slave (
      input  din, din_valid, din_last,
      output din_ready, bram_we, bram_addr, bram_din
   );

   modport master (
      output din, din_valid, din_last,
      input  din_ready, bram_we, bram_addr, bram_din
   );
endinterface

// File: rtl/weight_loader.sv
// Write-side controller for the neuron weight RAM: fills addresses 0..ADDR-1 from a
// framed stream and flags frames that end early or run long.
module weight_loader #(
   parameter  int ADDR      = 256,
   parameter  int DIN_WIDTH = 16,
   localparam int ADDR_W    = $clog2(ADDR)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   weight_loader_if.slave      bus,
   output logic                busy,
   output logic                load_done,
   output logic                err_short,
   output logic                err_overflow,
   output logic [ADDR_W:0]     word_count
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN} state_e;

   localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(ADDR - 1);

   state_e               state_q, state_d;
   logic                 we_q, we_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [DIN_WIDTH-1:0] data_q, data_d;
   logic [ADDR_W:0]      cnt_q, cnt_d;
   logic                 done_q, done_d;
   logic                 short_q, short_d;
   logic                 ovf_q, ovf_d;
   logic                 accept;

   // Ready depends only on state, so the host never sees a valid->ready loop.
   assign accept = bus.din_valid && (state_q != S_IDLE);

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it
      // unassigned, which would otherwise infer a latch.
      state_d = state_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      short_d = short_q;
      ovf_d   = ovf_q;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_LOAD;
               cnt_d   = '0;
               short_d = 1'b0;
               ovf_d   = 1'b0;
            end
         end
         S_LOAD: begin
            if (accept) begin
               we_d   = 1'b1;
               addr_d = cnt_q[ADDR_W-1:0];
               data_d = bus.din;
               cnt_d  = cnt_q + 1'b1;
               if (cnt_q == LAST_IDX) begin
                  if (bus.din_last) begin
                     state_d = S_IDLE;
                     done_d  = 1'b1;
                  end else begin
                     ovf_d   = 1'b1;
                     state_d = S_DRAIN;
                  end
               end else if (bus.din_last) begin
                  short_d = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         // Excess beats are swallowed until the frame's last marker resynchronises us.
         S_DRAIN: begin
            if (accept && bus.din_last) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         we_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         short_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         short_q <= short_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.din_ready = (state_q != S_IDLE);
   assign bus.bram_we   = we_q;
   assign bus.bram_addr = addr_q;
   assign bus.bram_din  = data_q;
   assign busy          = (state_q != S_IDLE);
   assign load_done     = done_q;
   assign err_short     = short_q;
   assign err_overflow  = ovf_q;
   assign word_count    = cnt_q;

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader: a negedge monitor records RAM writes and
// load_done pulses, and each scenario task compares them against hand-computed values.
module tb_weight_loader;

   localparam int ADDR      = 256;
   localparam int DIN_WIDTH = 16;
   localparam int ADDR_W    = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              busy, load_done, err_short, err_overflow;
   logic [ADDR_W:0]   word_count;

   int checks   = 0;
   int failures = 0;

   weight_loader_if #(.DIN_WIDTH(DIN_WIDTH), .ADDR_W(ADDR_W)) bus ();

   weight_loader #(.ADDR(ADDR), .DIN_WIDTH(DIN_WIDTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .bus          (bus.slave),
      .busy         (busy),
      .load_done    (load_done),
      .err_short    (err_short),
      .err_overflow (err_overflow),
      .word_count   (word_count)
   );

   always #5 clk = ~clk;

   // Write/pulse recorder
   int                   cyc = 0;
   int                   wr_n, done_n, done_bad;
   int                   wr_cyc  [0:511];
   logic [ADDR_W-1:0]    wr_addr [0:511];
   logic [DIN_WIDTH-1:0] wr_data [0:511];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.bram_we === 1'b1 && wr_n < 512) begin
         wr_addr[wr_n] = bus.bram_addr;
         wr_data[wr_n] = bus.bram_din;
         wr_cyc[wr_n]  = cyc;
         wr_n++;
      end
      if (load_done === 1'b1) begin
         done_n++;
         if (!(bus.bram_we === 1'b1 && bus.bram_addr == ADDR_W'(ADDR - 1))) done_bad++;
      end
   end

   task automatic clear_mon();
      wr_n = 0; done_n = 0; done_bad = 0;
   endtask

   // Number of recorded writes deviating from addr=k, data=base+k for k < n.
   function automatic int count_bad(input int n, input int base);
      int bad = 0;
      for (int k = 0; k < n; k++)
         if (wr_addr[k] !== ADDR_W'(k) || wr_data[k] !== DIN_WIDTH'(base + k)) bad++;
      return bad;
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic idle_inputs();
      start = 1'b0; bus.din_valid = 1'b0; bus.din_last = 1'b0; bus.din = '0;
   endtask

   task automatic pulse_start();
      start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic beat(input int data, input logic last);
      bus.din = DIN_WIDTH'(data); bus.din_valid = 1'b1; bus.din_last = last; tick();
   endtask

   task automatic send_frame(input int n, input int base);
      for (int i = 0; i < n; i++) beat(base + i, i == n - 1);
      idle_inputs();
   endtask

   task automatic check_full_frame(input string name, input int base);
      int bad;
      bad = count_bad(ADDR, base);
      checks++;
      if (wr_n !== ADDR) begin failures++; $display("FAIL %s write count: got %0d want %0d", name, wr_n, ADDR); end
      checks++;
      if (bad !== 0) begin failures++; $display("FAIL %s addr/data: %0d bad writes, want 0", name, bad); end
      checks++;
      if (done_n !== 1 || done_bad !== 0) begin failures++; $display("FAIL %s load_done: pulses=%0d misaligned=%0d want 1/0", name, done_n, done_bad); end
      checks++;
      if (word_count !== 9'd256 || err_short !== 1'b0 || err_overflow !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL %s status: wc=%0d short=%b ovf=%b busy=%b want 256/0/0/0", name, word_count, err_short, err_overflow, busy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; idle_inputs(); clear_mon();
      tick(); tick();
      checks++;
      if ({bus.bram_we, bus.bram_addr, bus.bram_din, bus.din_ready, busy, load_done, err_short, err_overflow, word_count} !== '0) begin
         failures++;
         $display("FAIL reset outputs: we=%b addr=%0d din=%0h rdy=%b busy=%b done=%b es=%b eo=%b wc=%0d want all 0",
                  bus.bram_we, bus.bram_addr, bus.bram_din, bus.din_ready, busy, load_done, err_short, err_overflow, word_count);
      end
      rst = 1'b0; tick();
   endtask

   task automatic test_idle_beats();
      int rdy_bad = 0;
      clear_mon();
      for (int i = 0; i < 5; i++) begin
         beat(16'h5000 + i, i == 4);
         if (bus.din_ready !== 1'b0) rdy_bad++;
      end
      idle_inputs(); tick();
      checks++;
      if (rdy_bad !== 0 || wr_n !== 0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL idle_beats: ready_high=%0d writes=%0d busy=%b want 0/0/0", rdy_bad, wr_n, busy);
      end
   endtask

   task automatic test_nominal();
      int span;
      clear_mon();
      pulse_start();
      checks++;
      if (busy !== 1'b1 || bus.din_ready !== 1'b1 || word_count !== 9'd0) begin
         failures++; $display("FAIL nominal armed: busy=%b rdy=%b wc=%0d want 1/1/0", busy, bus.din_ready, word_count);
      end
      send_frame(ADDR, 0);
      tick(); tick();
      check_full_frame("nominal", 0);
      span = wr_cyc[ADDR-1] - wr_cyc[0];
      checks++;
      if (span !== ADDR - 1) begin failures++; $display("FAIL nominal back_to_back span: got %0d want %0d", span, ADDR - 1); end
   endtask

   task automatic test_gapped();
      int idx = 0;
      int j = 0;
      clear_mon();
      pulse_start();
      while (idx < ADDR && j < 4 * ADDR) begin
         if (j % 4 == 0 || j % 4 == 3) begin
            beat(idx + 16'h1000, idx == ADDR - 1);
            idx++;
         end else begin
            // Idle cycles carry junk with last set: it must be ignored without valid.
            bus.din = 16'hDEAD; bus.din_valid = 1'b0; bus.din_last = 1'b1; tick();
         end
         j++;
      end
      idle_inputs(); tick(); tick();
      check_full_frame("gapped", 16'h1000);
   endtask

   task automatic test_short();
      int bad;
      clear_mon();
      pulse_start();
      send_frame(10, 16'h0200);
      tick(); tick(); tick();
      bad = count_bad(10, 16'h0200);
      checks++;
      if (wr_n !== 10 || bad !== 0) begin failures++; $display("FAIL short writes: n=%0d bad=%0d want 10/0", wr_n, bad); end
      checks++;
      if (err_short !== 1'b1 || err_overflow !== 1'b0 || done_n !== 0) begin
         failures++; $display("FAIL short flags: es=%b eo=%b done=%0d want 1/0/0", err_short, err_overflow, done_n);
      end
      checks++;
      if (word_count !== 9'd10 || bus.din_ready !== 1'b0 || busy !== 1'b0) begin
         failures++; $display("FAIL short state: wc=%0d rdy=%b busy=%b want 10/0/0", word_count, bus.din_ready, busy);
      end
   endtask

   task automatic test_restart_after_short();
      clear_mon();
      pulse_start();
      checks++;
      if (err_short !== 1'b0 || word_count !== 9'd0 || busy !== 1'b1) begin
         failures++; $display("FAIL restart clear: es=%b wc=%0d busy=%b want 0/0/1", err_short, word_count, busy);
      end
      send_frame(ADDR, 16'h3000);
      tick(); tick();
      check_full_frame("restart", 16'h3000);
   endtask

   task automatic test_overflow();
      int bad;
      clear_mon();
      pulse_start();
      for (int i = 0; i < 260; i++) begin
         if (i == 256) begin
            checks++;
            if (err_overflow !== 1'b1 || busy !== 1'b1 || bus.din_ready !== 1'b1) begin
               failures++; $display("FAIL overflow drain entry: eo=%b busy=%b rdy=%b want 1/1/1", err_overflow, busy, bus.din_ready);
            end
         end
         beat(i, i == 259);
      end
      idle_inputs(); tick(); tick();
      bad = count_bad(ADDR, 0);
      checks++;
      if (wr_n !== ADDR || bad !== 0) begin failures++; $display("FAIL overflow writes: n=%0d bad=%0d want 256/0", wr_n, bad); end
      checks++;
      if (err_overflow !== 1'b1 || err_short !== 1'b0 || done_n !== 0 || busy !== 1'b0 || word_count !== 9'd256) begin
         failures++;
         $display("FAIL overflow final: eo=%b es=%b done=%0d busy=%b wc=%0d want 1/0/0/0/256",
                  err_overflow, err_short, done_n, busy, word_count);
      end
   endtask

   task automatic test_reset_mid_load();
      clear_mon();
      pulse_start();
      for (int i = 0; i < 100; i++) beat(i, 1'b0);
      // A beat presented alongside reset must not turn into a write.
      rst = 1'b1; bus.din = 16'hBEEF; bus.din_valid = 1'b1; bus.din_last = 1'b0; tick();
      checks++;
      if ({bus.bram_we, bus.bram_addr, bus.bram_din, bus.din_ready, busy, load_done, err_short, err_overflow, word_count} !== '0) begin
         failures++;
         $display("FAIL reset_mid_load outputs: we=%b addr=%0d din=%0h rdy=%b busy=%b wc=%0d want all 0",
                  bus.bram_we, bus.bram_addr, bus.bram_din, bus.din_ready, busy, word_count);
      end
      checks++;
      if (wr_n !== 100) begin failures++; $display("FAIL reset_mid_load writes: got %0d want 100", wr_n); end
      rst = 1'b0; idle_inputs(); tick();
      clear_mon();
      pulse_start();
      send_frame(ADDR, 16'h4000);
      tick(); tick();
      check_full_frame("after_reset", 16'h4000);
   endtask

   task automatic test_start_corners();
      int bad;
      clear_mon();
      // start and a valid beat together: start wins, the beat is dropped.
      start = 1'b1; bus.din = 16'hAAAA; bus.din_valid = 1'b1; bus.din_last = 1'b0; tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) beat(16'h0100 + i, 1'b0);
      // start re-pulsed mid-frame together with a beat: ignored, the beat still counts.
      start = 1'b1; beat(16'h0105, 1'b0); start = 1'b0;
      for (int i = 6; i < 10; i++) beat(16'h0100 + i, i == 9);
      idle_inputs(); tick(); tick();
      bad = count_bad(10, 16'h0100);
      checks++;
      if (wr_n !== 10 || bad !== 0) begin failures++; $display("FAIL start_corners writes: n=%0d bad=%0d want 10/0", wr_n, bad); end
      checks++;
      if (word_count !== 9'd10 || err_short !== 1'b1 || done_n !== 0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL start_corners status: wc=%0d es=%b done=%0d busy=%b want 10/1/0/0", word_count, err_short, done_n, busy);
      end
   endtask

   initial begin
      test_reset();
      test_idle_beats();
      test_nominal();
      test_gapped();
      test_short();
      test_restart_after_short();
      test_overflow();
      test_reset_mid_load();
      test_start_corners();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/weight_loader.md
Name: weight_loader

Overview:
- Write-side controller for the neuron weight memory. Accepts a framed stream of weight words from the host/loader path.
- Produces a registered RAM write port (we/addr/data) that fills addresses 0..ADDR-1 in order.
- Flags frames that are too short or too long. The sequential weight reader later consumes the same RAM.

Parameters:
- ADDR, 256, number of weight words per frame (RAM depth); must be >= 2.
- DIN_WIDTH, 16, width of one weight word (matches the reader's output width).
- ADDR_W, $clog2(ADDR), RAM address width (derived; do not override).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  single-cycle pulse that arms a new frame load
- din  input  DIN_WIDTH  weight word
- din_valid  input  1  din is valid this cycle
- din_last  input  1  marks the final word of the frame; qualified by din_valid
- din_ready  output  1  loader accepts a beat when din_valid && din_ready
- bram_we  output  1  RAM write enable
- bram_addr  output  ADDR_W  RAM write address
- bram_din  output  DIN_WIDTH  RAM write data
- busy  output  1  high in LOAD or DRAIN
- load_done  output  1  one-cycle pulse when a correct frame completes
- err_short  output  1  sticky: frame ended before ADDR words
- err_overflow  output  1  sticky: frame exceeded ADDR words
- word_count  output  ADDR_W+1  number of words written in the current/last frame

Behaviour:
- Reset: all outputs 0, state IDLE, word_count 0. Sticky errors clear.
- States: IDLE, LOAD, DRAIN.
- IDLE
  - din_ready=0.
  - start -> LOAD on the next cycle; clears word_count, err_short and err_overflow.
  - Beats presented in IDLE are not accepted.
- LOAD
  - din_ready=1 combinationally from state (no dependency on din_valid).
  - Accepted beat k (k = 0-based word_count before the beat):
    - next cycle: bram_we=1, bram_addr=k, bram_din=din (write latency 1 cycle, registered);
    - word_count increments on the same edge.
- LOAD exits:
  - Accepted beat with k == ADDR-1 and din_last=1: write it, -> IDLE, load_done=1 in the same cycle as that final bram_we.
  - Accepted beat with din_last=1 and k < ADDR-1: write it, err_short=1, -> IDLE, no load_done.
  - Accepted beat with k == ADDR-1 and din_last=0: write it, err_overflow=1, -> DRAIN.
- DRAIN
  - din_ready=1; beats are consumed but never written (bram_we=0, word_count holds at ADDR).
  - Accepted beat with din_last=1 -> IDLE.
- bram_we is 0 in every cycle that does not follow an accepted LOAD beat. bram_addr and bram_din hold their last values when bram_we=0.
- start while busy is ignored.
- start and din_valid in the same IDLE cycle: start is taken, the beat is not accepted (din_ready=0 that cycle).
- Gaps in din_valid during LOAD are allowed; the address advances only on accepted beats.
- Address never wraps: at most ADDR writes per frame. The overflow path guarantees bram_addr never exceeds ADDR-1.
- Reset mid-load: returns to IDLE at once. Any in-flight registered write is cancelled (bram_we=0 in the cycle after rst). RAM contents stay partially written and are not valid until a later frame gives load_done.
- word_count and the error flags hold their values in IDLE until the next start.

Test Plan:
- Nominal frame, ADDR=256: start, then 256 back-to-back beats with din=i (i=0..255), last on i=255.
  -> 256 writes with bram_addr=i, bram_din=i, consecutive cycles;
  -> load_done pulses exactly once with the addr-255 write; word_count=256; no errors; busy low after.
- Gapped valid: same frame, din_valid toggled 1,0,0,1 pattern.
  -> writes only after accepted beats, addresses contiguous 0..255, load_done once.
- Short frame: start, 10 beats with last on beat 9.
  -> writes to addr 0..9; err_short=1; load_done=0; word_count=10; state IDLE (din_ready=0).
- Overflow: start, 260 beats, last on beat 259.
  -> writes only addr 0..255; err_overflow=1 after beat 255; beats 256..259 accepted with bram_we=0; returns to IDLE after beat 259; no load_done.
- Reset mid-load: assert rst for 1 cycle after 100 accepted beats.
  -> next cycle all outputs 0; no bram_we.
  -> A following start plus full frame completes normally from addr 0.
- Control corner cases:
  - beats in IDLE without start -> din_ready=0, no writes;
  - start pulsed during LOAD -> ignored, word_count unaffected;
  - new start after an err_short -> errors clear, load restarts at addr 0.
